// File: rtl/hack_mem_pkg.sv
// Shared address map, region type and decode for the Hack data-memory stage.
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    localparam int RAM_WORDS    = int'(SCREEN_BASE - RAM_BASE);
    localparam int SCREEN_WORDS = int'(KBD_ADDR - SCREEN_BASE);
    localparam int RAM_AW       = $clog2(RAM_WORDS);
    localparam int SCREEN_AW    = $clog2(SCREEN_WORDS);

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } mem_region_t;

    function automatic mem_region_t decode_region(input logic [ADDR_W-1:0] addr);
        if (addr < SCREEN_BASE) begin
            return REG_RAM;
        end else if (addr < KBD_ADDR) begin
            return REG_SCREEN;
        end else if (addr == KBD_ADDR) begin
            return REG_KBD;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/hack_key_fifo.sv
// Key-event FIFO; head reads as zero when empty, and a pop frees room for a
// push on the same edge.
module hack_key_fifo
    import hack_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, dual-port screen buffer and keyboard register.
// Define HACK_KBD_FIFO_EN to queue key events in a KBD_DEPTH-entry FIFO.
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int KBD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    outM,
    input  logic                 writeM,
    input  logic [ADDR_W-1:0]    addressM,
    output logic [DATA_W-1:0]    inM,
    input  logic [SCREEN_AW-1:0] scan_addr,
    output logic [DATA_W-1:0]    scan_data,
    input  logic                 kbd_valid,
    input  logic [DATA_W-1:0]    kbd_code,
    output logic                 kbd_ready,
    output logic                 bad_access
);

    mem_region_t       region;
    logic [DATA_W-1:0] ram    [0:RAM_WORDS-1];
    logic [DATA_W-1:0] screen [0:SCREEN_WORDS-1];
    logic [DATA_W-1:0] key_value;

    assign region = decode_region(addressM);

    // A write coinciding with reset is dropped; contents themselves are never cleared.
    always_ff @(posedge clk) begin
        if (!reset && writeM && (region == REG_RAM))
            ram[addressM[RAM_AW-1:0]] <= outM;
    end

    always_ff @(posedge clk) begin
        if (!reset && writeM && (region == REG_SCREEN))
            screen[addressM[SCREEN_AW-1:0]] <= outM;
    end

    // Scanner port samples the pre-edge word, so a same-edge CPU write is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) scan_data <= '0;
        else       scan_data <= screen[scan_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               bad_access <= 1'b0;
        else if (writeM && (region == REG_NONE)) bad_access <= 1'b1;
    end

    always_comb begin
        inM = '0;
        case (region)
            REG_RAM:    inM = ram[addressM[RAM_AW-1:0]];
            REG_SCREEN: inM = screen[addressM[SCREEN_AW-1:0]];
            REG_KBD:    inM = key_value;
            default:    inM = '0;
        endcase
    end

`ifdef HACK_KBD_FIFO_EN
    logic kbd_pop;
    logic fifo_full;

    // A pop on the same edge makes room, so a full FIFO still takes the event.
    assign kbd_pop   = writeM && (region == REG_KBD);
    assign kbd_ready = !fifo_full || kbd_pop;

    hack_key_fifo #(
        .DEPTH(KBD_DEPTH)
    ) u_key_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_valid && kbd_ready),
        .push_data (kbd_code),
        .pop       (kbd_pop),
        .head      (key_value),
        .full      (fifo_full)
    );
`else
    logic [31:0] unused_kbd_depth;

    assign unused_kbd_depth = KBD_DEPTH;
    assign kbd_ready        = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          key_value <= '0;
        else if (kbd_valid) key_value <= kbd_code;
    end
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed plus randomized bench for hack_data_memory against a queue/array model.
module tb_hack_data_memory;

`ifdef HACK_KBD_FIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [15:0] inM;
    logic [12:0] scan_addr;
    logic [15:0] scan_data;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic        bad_access;

    hack_data_memory #(.KBD_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .outM       (outM),
        .writeM     (writeM),
        .addressM   (addressM),
        .inM        (inM),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .kbd_valid  (kbd_valid),
        .kbd_code   (kbd_code),
        .kbd_ready  (kbd_ready),
        .bad_access (bad_access)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kq [$];
    logic [15:0] key_m;
    bit          bad_m;
    logic [15:0] scan_m;
    bit          scan_known;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit pop_now();
        return writeM && (int'(addressM) == 'h6000);
    endfunction

    function automatic bit exp_ready();
        if (!FIFO_ON) return 1'b1;
        return (kq.size() < DEPTH) || pop_now();
    endfunction

    function automatic logic [15:0] exp_key();
        if (FIFO_ON) return (kq.size() > 0) ? kq[0] : 16'h0000;
        return key_m;
    endfunction

    task automatic model_reset();
        kq.delete();
        key_m      = 16'h0000;
        bad_m      = 1'b0;
        scan_m     = 16'h0000;
        scan_known = 1'b1;
    endtask

    task automatic model_edge();
        int  a;
        bit  acc;
        if (reset) begin
            model_reset();
            return;
        end
        a = int'(addressM);
        if (scr_m.exists(int'(scan_addr))) begin
            scan_m     = scr_m[int'(scan_addr)];
            scan_known = 1'b1;
        end else begin
            scan_known = 1'b0;
        end
        acc = kbd_valid && exp_ready();
        if (FIFO_ON) begin
            if (pop_now() && kq.size() > 0) void'(kq.pop_front());
            if (acc) kq.push_back(kbd_code);
        end else if (kbd_valid) begin
            key_m = kbd_code;
        end
        if (writeM) begin
            if (a < 'h4000)      ram_m[a] = outM;
            else if (a < 'h6000) scr_m[a - 'h4000] = outM;
            else if (a > 'h6000) bad_m = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int a;
        a = int'(addressM);
        if (a < 'h4000) begin
            if (ram_m.exists(a)) chk("inM_ram", inM, ram_m[a]);
        end else if (a < 'h6000) begin
            if (scr_m.exists(a - 'h4000)) chk("inM_screen", inM, scr_m[a - 'h4000]);
        end else if (a == 'h6000) begin
            chk("inM_kbd", inM, exp_key());
        end else begin
            chk("inM_unmapped", inM, 16'h0000);
        end
        chk("kbd_ready", {15'b0, kbd_ready}, {15'b0, exp_ready()});
        chk("bad_access", {15'b0, bad_access}, {15'b0, bad_m});
        if (scan_known) chk("scan_data", scan_data, scan_m);
    endtask

    task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic we,
                         input logic [12:0] sa, input logic kv, input logic [15:0] kc);
        addressM  = a;
        outM      = d;
        writeM    = we;
        scan_addr = sa;
        kbd_valid = kv;
        kbd_code  = kc;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("rst_scan", scan_data, 16'h0000);
        chk("rst_ready", {15'b0, kbd_ready}, 16'h0001);
        chk("rst_bad", {15'b0, bad_access}, 16'h0000);
        chk("rst_kbd", inM, 16'h0000);
        tick();
        reset = 1'b0;

        // RAM write then read-back
        drive(15'h0005, 16'h1234, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h0005, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_ram", inM, 16'h1234);

        // Screen write, then scanner read
        drive(15'h4000, 16'hFFFF, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h4000, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h0005, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_scan", scan_data, 16'hFFFF);

        // Read-before-write on the scanner port
        drive(15'h4010, 16'h5555, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h4010, 16'hAAAA, 1'b1, 13'h010, 1'b0, 16'h0);
        tick();
        drive(15'h4010, 16'h0000, 1'b0, 13'h010, 1'b0, 16'h0);
        chk("plan_rbw_old", scan_data, 16'h5555);
        tick();
        drive(15'h4010, 16'h0000, 1'b0, 13'h010, 1'b0, 16'h0);
        chk("plan_rbw_new", scan_data, 16'hAAAA);

        // Unmapped write sets the sticky flag; unmapped read is zero
        drive(15'h6005, 16'hDEAD, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h6005, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_bad_set", {15'b0, bad_access}, 16'h0001);
        chk("plan_unmapped_rd", inM, 16'h0000);
        tick();
        tick();
        drive(15'h7FFF, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_bad_sticky", {15'b0, bad_access}, 16'h0001);
        reset = 1'b1;
        model_reset();
        drive(15'h0005, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_rst_bad", {15'b0, bad_access}, 16'h0000);
        chk("plan_rst_scan", scan_data, 16'h0000);
        tick();
        reset = 1'b0;

        // Keyboard: four events, a fifth while possibly full, then a pop
        for (int i = 0; i < 4; i++) begin
            drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h0041 + 16'(i));
            tick();
        end
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h0045);
        if (FIFO_ON) begin
            chk("plan_full_ready", {15'b0, kbd_ready}, 16'h0000);
            chk("plan_head", inM, 16'h0041);
        end else begin
            chk("plan_last_key", inM, 16'h0044);
        end
        tick();
        drive(15'h6000, 16'h1111, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);
        if (FIFO_ON) chk("plan_pop_head", inM, 16'h0042);
        chk("plan_ready_after", {15'b0, kbd_ready}, 16'h0001);
        // Refill, then pop and push on the same edge
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h0046);
        tick();
        drive(15'h6000, 16'h2222, 1'b1, 13'h0, 1'b1, 16'h0047);
        tick();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h0000);
        tick();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);

        // Asynchronous reset with events queued and a write in flight
        drive(15'h0007, 16'hBEEF, 1'b1, 13'h0, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h0061 + 16'(i));
            tick();
        end
        reset = 1'b1;
        model_reset();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_async_kbd", inM, 16'h0000);
        chk("plan_async_ready", {15'b0, kbd_ready}, 16'h0001);
        drive(15'h0007, 16'h0BAD, 1'b1, 13'h0, 1'b1, 16'h0099);
        tick();
        reset = 1'b0;
        drive(15'h0007, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_ram_kept", inM, 16'hBEEF);
        drive(15'h0005, 16'h0000, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_ram_kept2", inM, 16'h1234);

        // Push and pop together on an empty queue
        drive(15'h6000, 16'h3333, 1'b1, 13'h0, 1'b1, 16'h0077);
        tick();
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);
        chk("plan_empty_pushpop", inM, 16'h0077);

        // Randomized traffic over small address windows
        for (int i = 0; i < 600; i++) begin
            logic [14:0] a;
            logic [12:0] sa;
            case ($urandom_range(0, 9))
                0, 1, 2: a = 15'($urandom_range(0, 15));
                3, 4, 5: a = 15'h4000 + 15'($urandom_range(0, 15));
                6, 7:    a = 15'h6000;
                8:       a = 15'h3FF0 + 15'($urandom_range(0, 15));
                default: a = 15'h6001 + 15'($urandom_range(0, 'h1FFE));
            endcase
            sa = ($urandom_range(0, 7) == 0) ? 13'h1FF0 + 13'($urandom_range(0, 15))
                                             : 13'($urandom_range(0, 15));
            drive(a, 16'($urandom), ($urandom_range(0, 9) < 4) && !(a > 15'h6000 && $urandom_range(0, 7) != 0),
                  sa, $urandom_range(0, 2) == 0, 16'($urandom));
            tick();
        end
        drive(15'h6000, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hack_data_memory.md
# hack_data_memory

Data-memory stage directly downstream of the Hack CPU. It consumes the CPU's `outM`, `writeM` and `addressM` and returns `inM`. It decodes the 15-bit address space into:
- a 16K-word RAM,
- an 8K-word screen buffer with a second, registered read port for the display scanner,
- a keyboard register fed by a valid/ready key-event stream.

It replaces the flat RAM previously wired to the CPU and is the only memory-mapped I/O point in the system.

## Interface
Parameters:
- `KBD_DEPTH`, default 4: key-event FIFO depth. Power of two, ≥2. Used only when `HACK_KBD_FIFO_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `outM`  in  16  CPU write data
- `writeM`  in  1  CPU write strobe
- `addressM`  in  15  CPU data address
- `inM`  out  16  CPU read data (combinational)
- `scan_addr`  in  13  display scanner word address within the screen buffer
- `scan_data`  out  16  screen word at the previous cycle's `scan_addr`
- `kbd_valid`  in  1  key event present
- `kbd_code`  in  16  key code; 0 = all keys released
- `kbd_ready`  out  1  keyboard stage accepts an event this cycle
- `bad_access`  out  1  sticky flag: an access was made to an unmapped address

## Operation
- Address decode:
  - 0x0000–0x3FFF: RAM.
  - 0x4000–0x5FFF: screen, index = `addressM[12:0]`.
  - 0x6000: KBD.
  - 0x6001–0x7FFF: unmapped.
- Writes:
  - When `writeM`=1, RAM or screen word ← `outM` at the rising edge.
  - Unmapped writes are dropped and set `bad_access`.
  - KBD writes: see Configuration.
- Reads:
  - `inM` = selected word, combinational from `addressM`.
  - A KBD read returns the current key value.
  - An unmapped read returns 0x0000. Unmapped reads do not set `bad_access`, because the CPU drives `addressM` every cycle.
- Keyboard:
  - An event is accepted when `kbd_valid`&&`kbd_ready` at the rising edge.
  - `kbd_code` passes through unchanged; no translation.
- Scanner port:
  - Independent read-only port.
  - Never stalls and never blocks CPU access.
- `bad_access` clears only on `reset`.
- RAM and screen contents are not cleared by reset; after power-up they are undefined to the bench.

## Timing
- Reset values: `scan_data`=0, key value=0, `kbd_ready`=1, `bad_access`=0, FIFO empty.
- CPU write is visible on `inM` in the cycle after the edge. No CPU read latency.
- `scan_data` latency is 1 cycle.
- Simultaneous CPU write and scanner read of the same screen word: `scan_data` returns the old word (read-before-write).
- An accepted key event is visible on `inM` at 0x6000 from the next cycle.
- Reset asserted mid-operation:
  - Pending FIFO events are discarded.
  - The in-flight write at that edge is dropped.
  - Memory contents are untouched.

## Configuration
- `HACK_KBD_FIFO_EN` defined:
  - KBD_DEPTH-entry FIFO of key events.
  - KBD read returns the FIFO head, or 0 when the FIFO is empty.
  - A CPU write of any value to 0x6000 pops the head. A pop on an empty FIFO is ignored.
  - `kbd_ready`=0 when full.
  - Simultaneous push and pop with the FIFO full: the pop completes and the push is accepted in the same edge.
  - Simultaneous push and pop with the FIFO empty: the push is stored and the pop is ignored.
- `HACK_KBD_FIFO_EN` undefined:
  - Single holding register; each accepted event overwrites it.
  - `kbd_ready` is tied to 1.
  - CPU writes to 0x6000 are ignored and do not set `bad_access`.
  - Standard Hack keyboard semantics.

## Structure
- Package `hack_mem_pkg` holds:
  - `RAM_BASE`, `SCREEN_BASE`, `KBD_ADDR` and `ADDR_W`=15.
  - Region enum `mem_region_t` {`REG_RAM`, `REG_SCREEN`, `REG_KBD`, `REG_NONE`}.
  - Decode function `decode_region`.
- Sub-module `hack_key_fifo` holds the FIFO:
  - Pointers with an extra wrap bit; full/empty flags.
  - Instantiated only under `HACK_KBD_FIFO_EN`.
- Screen buffer: dual-port (CPU read/write async read, scanner registered read).

## Test plan
- Write 0x1234 to 0x0005, then read 0x0005 → `inM`=0x1234 next cycle. Write 0xFFFF to 0x4000; `scan_addr`=0 → `scan_data`=0xFFFF one cycle later.
- Same edge: CPU writes 0xAAAA to 0x4010 while `scan_addr`=0x010 holds 0x5555 → `scan_data`=0x5555; the next scan returns 0xAAAA.
- Write to 0x6005 → `bad_access`=1 and stays set; read 0x6005 → 0; `reset` → `bad_access`=0, `scan_data`=0.
- FIFO off: events 0x0041 then 0x0000 → KBD reads 0x41, then 0; `kbd_ready` stays 1.
- FIFO on, depth 4: push 0x41, 0x42, 0x43, 0x44 → `kbd_ready`=0. A fifth event is held off. KBD reads 0x41. Write to 0x6000 → KBD reads 0x42 and `kbd_ready`=1.
- FIFO on: assert `reset` with 3 events queued → KBD=0 and `kbd_ready`=1 immediately (asynchronous); a previously written RAM word still reads back unchanged.
